// File: rtl/hazard_pkg.sv
// Shared constants for the 5-stage MIPS hazard control: control-bundle bit
// positions, forwarding and PC-select encodings, and the hazard FSM states.
package hazard_pkg;

  localparam int CTRL_W_DEF       = 11;
  localparam int BIT_REGWRITE_DEF = 0;
  localparam int BIT_MEMREAD_DEF  = 1;
  localparam int BIT_BRANCH_DEF   = 4;
  localparam int BIT_JUMP_DEF     = 5;
  localparam int CNT_W_DEF        = 16;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [1:0] PCSEL_PC4    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_fwd.sv
// ALU operand forwarding select: EX/MEM result beats MEM/WB result, and
// register $0 is never forwarded.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_id_ex_rs,
  input  logic [4:0] i_id_ex_rt,
  input  logic       i_ex_mem_regwrite,
  input  logic [4:0] i_ex_mem_wr_reg,
  input  logic       i_mem_wb_regwrite,
  input  logic [4:0] i_mem_wb_wr_reg,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       em_wr,
                                         input logic [4:0] em_reg,
                                         input logic       mw_wr,
                                         input logic [4:0] mw_reg);
    if (em_wr && (em_reg != 5'd0) && (em_reg == src))
      return FWD_EXMEM;
    else if (mw_wr && (mw_reg != 5'd0) && (mw_reg == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  assign o_fwd_a = fwd_sel(i_id_ex_rs, i_ex_mem_regwrite, i_ex_mem_wr_reg,
                           i_mem_wb_regwrite, i_mem_wb_wr_reg);
  assign o_fwd_b = fwd_sel(i_id_ex_rt, i_ex_mem_regwrite, i_ex_mem_wr_reg,
                           i_mem_wb_regwrite, i_mem_wb_wr_reg);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait freeze, branch/jump squash, load-use
// stall, operand forwarding and a saturating count of stalled cycles.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CTRL_W       = CTRL_W_DEF,
  parameter int BIT_REGWRITE = BIT_REGWRITE_DEF,
  parameter int BIT_MEMREAD  = BIT_MEMREAD_DEF,
  parameter int BIT_BRANCH   = BIT_BRANCH_DEF,
  parameter int BIT_JUMP     = BIT_JUMP_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic [4:0]        id_ex_rs,
  input  logic [4:0]        id_ex_rt,
  input  logic [CTRL_W-1:0] id_ex_ctrl,
  input  logic [4:0]        ex_mem_wr_reg,
  input  logic [CTRL_W-1:0] ex_mem_ctrl,
  input  logic              ex_mem_zero,
  input  logic [4:0]        mem_wb_wr_reg,
  input  logic [CTRL_W-1:0] mem_wb_ctrl,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        pc_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  hazard_state_t    r_state;
  hazard_state_t    w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_branch_taken;
  logic             w_jump;
  logic             w_load_use;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused;

  assign w_branch_taken = ex_mem_ctrl[BIT_BRANCH] & ex_mem_zero;
  assign w_jump         = id_ex_ctrl[BIT_JUMP];
  assign w_load_use     = id_ex_ctrl[BIT_MEMREAD] && (id_ex_rt != 5'd0) &&
                          ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  // Only the bits above are consumed; the state is kept for debug visibility.
  assign w_unused = ^{id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, r_state};

  forwarding_unit u_fwd (
    .i_id_ex_rs        (id_ex_rs),
    .i_id_ex_rt        (id_ex_rt),
    .i_ex_mem_regwrite (ex_mem_ctrl[BIT_REGWRITE]),
    .i_ex_mem_wr_reg   (ex_mem_wr_reg),
    .i_mem_wb_regwrite (mem_wb_ctrl[BIT_REGWRITE]),
    .i_mem_wb_wr_reg   (mem_wb_wr_reg),
    .o_fwd_a           (w_fwd_a),
    .o_fwd_b           (w_fwd_b)
  );

  // Priority: reset > mem_busy > branch > jump > load-use > normal.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = PCSEL_PC4;
    fwd_a        = w_fwd_a;
    fwd_b        = w_fwd_b;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      fwd_a        = FWD_REG;
      fwd_b        = FWD_REG;
    end else if (mem_busy) begin
      // Freezing EX/MEM keeps a pending taken branch alive across the wait.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (w_branch_taken) begin
      pc_sel       = PCSEL_BRANCH;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_jump) begin
      pc_sel      = PCSEL_JUMP;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    w_next_state = ST_RUN;
    if (mem_busy)
      w_next_state = ST_MEM_WAIT;
    else if (!w_branch_taken && !w_jump && w_load_use)
      w_next_state = ST_LU_STALL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; a second narrow-counter instance
// shares the stimulus to exercise counter saturation.
module tb_hazard_control_unit;

  localparam logic [10:0] C_RW  = 11'h001;
  localparam logic [10:0] C_LW  = 11'h003;
  localparam logic [10:0] C_BR  = 11'h010;
  localparam logic [10:0] C_JMP = 11'h020;

  // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_fl,id_ex_fl,ex_mem_fl,pc_sel}
  localparam logic [9:0] E_NORM = 10'b11111_000_00;
  localparam logic [9:0] E_RST  = 10'b00000_111_00;
  localparam logic [9:0] E_LU   = 10'b00111_010_00;
  localparam logic [9:0] E_BR   = 10'b11111_111_01;
  localparam logic [9:0] E_JMP  = 10'b11111_110_10;
  localparam logic [9:0] E_FRZ  = 10'b00000_000_00;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rs, id_ex_rt;
  logic [10:0] id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
  logic [4:0]  ex_mem_wr_reg, mem_wb_wr_reg;
  logic        ex_mem_zero, mem_busy;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic [1:0]  s_pc_sel, s_fwd_a, s_fwd_b;
  logic [2:0]  s_stall_cnt;

  logic [9:0]  ctl;
  logic [15:0] exp_cnt;
  int          vecs = 0;
  int          errs = 0;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_sel};

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_ctrl(id_ex_ctrl),
    .ex_mem_wr_reg(ex_mem_wr_reg), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_zero(ex_mem_zero),
    .mem_wb_wr_reg(mem_wb_wr_reg), .mem_wb_ctrl(mem_wb_ctrl), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_control_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_ctrl(id_ex_ctrl),
    .ex_mem_wr_reg(ex_mem_wr_reg), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_zero(ex_mem_zero),
    .mem_wb_wr_reg(mem_wb_wr_reg), .mem_wb_ctrl(mem_wb_ctrl), .mem_busy(mem_busy),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
    .pc_sel(s_pc_sel), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    id_ex_ctrl = '0; ex_mem_ctrl = '0; mem_wb_ctrl = '0;
    ex_mem_wr_reg = 5'd0; mem_wb_wr_reg = 5'd0;
    ex_mem_zero = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    ex_mem_ctrl = C_RW; ex_mem_wr_reg = 5'd5; id_ex_rs = 5'd5;
    #1;
    vecs++; if (ctl !== E_RST) begin errs++; $display("FAIL rst_ctl: got %b want %b", ctl, E_RST); end
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL rst_fwd_a: got %b want 00", fwd_a); end
    vecs++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    cyc();
    reset = 1'b0;
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL post_rst_ctl: got %b want %b", ctl, E_NORM); end
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL post_rst_fwd_a: got %b want 10", fwd_a); end
    cyc();
    vecs++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL post_rst_cnt: got %0d want 0", stall_cnt); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_load_use();
    idle(); id_ex_ctrl = C_LW; id_ex_rt = 5'd2; if_id_rs = 5'd2; if_id_rt = 5'd4;
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, E_LU); end
    cyc(); exp_cnt = exp_cnt + 16'd1;
    idle();
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL lu_after_ctl: got %b want %b", ctl, E_NORM); end
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    id_ex_ctrl = C_LW; id_ex_rt = 5'd7; if_id_rs = 5'd1; if_id_rt = 5'd7;
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, E_LU); end
    cyc(); exp_cnt = exp_cnt + 16'd1;
    idle(); id_ex_ctrl = C_LW; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, E_NORM); end
    id_ex_ctrl = C_RW; id_ex_rt = 5'd3; if_id_rs = 5'd3;
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL lu_noload_ctl: got %b want %b", ctl, E_NORM); end
    cyc();
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL lu_nostall_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_forwarding();
    idle(); ex_mem_ctrl = C_RW; ex_mem_wr_reg = 5'd5; mem_wb_ctrl = C_RW; mem_wb_wr_reg = 5'd5;
    id_ex_rs = 5'd5; id_ex_rt = 5'd5;
    #1;
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL fwd_a_both: got %b want 10", fwd_a); end
    vecs++; if (fwd_b !== 2'b10) begin errs++; $display("FAIL fwd_b_both: got %b want 10", fwd_b); end
    ex_mem_ctrl = '0;
    #1;
    vecs++; if (fwd_a !== 2'b01) begin errs++; $display("FAIL fwd_a_memwb: got %b want 01", fwd_a); end
    ex_mem_ctrl = C_RW; ex_mem_wr_reg = 5'd0; mem_wb_wr_reg = 5'd0; id_ex_rs = 5'd0; id_ex_rt = 5'd0;
    #1;
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL fwd_a_r0: got %b want 00", fwd_a); end
    ex_mem_wr_reg = 5'd5; mem_wb_wr_reg = 5'd9; id_ex_rs = 5'd5; id_ex_rt = 5'd9;
    #1;
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL fwd_a_split: got %b want 10", fwd_a); end
    vecs++; if (fwd_b !== 2'b01) begin errs++; $display("FAIL fwd_b_split: got %b want 01", fwd_b); end
    id_ex_rt = 5'd4;
    #1;
    vecs++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL fwd_b_none: got %b want 00", fwd_b); end
    // forwarding still valid while stalling
    id_ex_ctrl = C_LW; id_ex_rt = 5'd9; if_id_rt = 5'd9; id_ex_rs = 5'd5;
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL fwd_stall_ctl: got %b want %b", ctl, E_LU); end
    vecs++; if ({fwd_a, fwd_b} !== 4'b1001) begin errs++; $display("FAIL fwd_stall_fwd: got %b want 1001", {fwd_a, fwd_b}); end
    cyc(); exp_cnt = exp_cnt + 16'd1;
    idle();
  endtask

  task automatic test_branch_jump();
    idle(); ex_mem_ctrl = C_BR; ex_mem_zero = 1'b1;
    #1;
    vecs++; if (ctl !== E_BR) begin errs++; $display("FAIL br_taken_ctl: got %b want %b", ctl, E_BR); end
    cyc();
    idle();
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL br_after_ctl: got %b want %b", ctl, E_NORM); end
    ex_mem_ctrl = C_BR; ex_mem_zero = 1'b0;
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL br_nottaken_ctl: got %b want %b", ctl, E_NORM); end
    idle(); id_ex_ctrl = C_JMP;
    #1;
    vecs++; if (ctl !== E_JMP) begin errs++; $display("FAIL jmp_ctl: got %b want %b", ctl, E_JMP); end
    ex_mem_ctrl = C_BR; ex_mem_zero = 1'b1;
    #1;
    vecs++; if (ctl !== E_BR) begin errs++; $display("FAIL br_over_jmp_ctl: got %b want %b", ctl, E_BR); end
    cyc();
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL brjmp_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush_vs_load_use();
    idle(); id_ex_ctrl = C_LW; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    ex_mem_ctrl = C_BR; ex_mem_zero = 1'b1;
    #1;
    vecs++; if (ctl !== E_BR) begin errs++; $display("FAIL br_lu_ctl: got %b want %b", ctl, E_BR); end
    cyc();
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL br_lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    idle(); id_ex_ctrl = C_LW | C_JMP; id_ex_rt = 5'd6; if_id_rt = 5'd6;
    #1;
    vecs++; if (ctl !== E_JMP) begin errs++; $display("FAIL jmp_lu_ctl: got %b want %b", ctl, E_JMP); end
    cyc();
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL jmp_lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_mem_wait();
    idle(); ex_mem_ctrl = C_BR; ex_mem_zero = 1'b1; mem_busy = 1'b1;
    id_ex_ctrl = C_LW; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (ctl !== E_FRZ) begin errs++; $display("FAIL memwait_ctl[%0d]: got %b want %b", i, ctl, E_FRZ); end
      cyc(); exp_cnt = exp_cnt + 16'd1;
    end
    mem_busy = 1'b0;
    #1;
    vecs++; if (ctl !== E_BR) begin errs++; $display("FAIL memwait_br_ctl: got %b want %b", ctl, E_BR); end
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL memwait_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    cyc();
    idle();
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL memwait_after_ctl: got %b want %b", ctl, E_NORM); end
    vecs++; if (stall_cnt !== exp_cnt) begin errs++; $display("FAIL memwait_after_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset_in_stall();
    idle(); id_ex_ctrl = C_LW; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    #1;
    vecs++; if (ctl !== E_LU) begin errs++; $display("FAIL rst_lu_ctl: got %b want %b", ctl, E_LU); end
    cyc();
    reset = 1'b1;
    #1;
    vecs++; if (ctl !== E_RST) begin errs++; $display("FAIL rst_in_stall_ctl: got %b want %b", ctl, E_RST); end
    cyc();
    reset = 1'b0; idle();
    #1;
    vecs++; if (ctl !== E_NORM) begin errs++; $display("FAIL rst_stall_after_ctl: got %b want %b", ctl, E_NORM); end
    vecs++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_saturation();
    idle(); mem_busy = 1'b1;
    repeat (10) cyc();
    mem_busy = 1'b0;
    #1;
    vecs++; if (stall_cnt !== 16'd10) begin errs++; $display("FAIL sat_wide_cnt: got %0d want 10", stall_cnt); end
    vecs++; if (s_stall_cnt !== 3'd7) begin errs++; $display("FAIL sat_narrow_cnt: got %0d want 7", s_stall_cnt); end
    cyc();
    vecs++; if (s_stall_cnt !== 3'd7) begin errs++; $display("FAIL sat_hold_cnt: got %0d want 7", s_stall_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    exp_cnt = 16'd0;
    idle();
    cyc();
    cyc();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_jump();
    test_flush_vs_load_use();
    test_mem_wait();
    test_reset_in_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
